ps2_key_tracker: RTL and testbench

//  Parametrised PS/2 scancode-set-2 decoder. Sits behind PS2_Controller (received_data/_en)
//  and tracks the held/pressed/released state of NUM_KEYS configurable keys, normal or
//  E0-extended, for the car-game control FSM. Handles E0/F0 prefixes, prefix timeout,
//  the 8-byte Pause (E1) sequence and controller housekeeping bytes.

---
 rtl/ps2_key_tracker.sv | 155 +++++++++++++++
 tb/tb_ps2_key_tracker.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// PS/2 scancode-set-2 key tracker: E0/F0 prefix decode, Pause skip, prefix timeout.
// Optional KEY_TYPEMATIC_EN: every make (including typematic repeats) pulses key_press.
module ps2_key_tracker #(
  parameter int unsigned            NUM_KEYS       = 3,
  parameter logic [8*NUM_KEYS-1:0]  KEY_CODES      = 24'h74_6B_5A,
  parameter logic [NUM_KEYS-1:0]    KEY_EXT        = 3'b110,
  parameter int unsigned            PREFIX_TIMEOUT = 500000
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [7:0]          received_data,
  input  logic                received_data_en,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                any_held,
  output logic                decode_error
);

  localparam int unsigned    TmoW    = $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(PREFIX_TIMEOUT - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StExt    = 3'd1;
  localparam logic [2:0] StBrk    = 3'd2;
  localparam logic [2:0] StExtBrk = 3'd3;
  localparam logic [2:0] StSkip   = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [2:0]          skip_q, skip_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic [NUM_KEYS-1:0] held_q, held_d;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] rel_q, rel_d;
  logic                err_q, err_d;

  logic is_make, is_brk, is_ext, is_prefix, is_house;

  assign is_prefix = (received_data == 8'hE0) || (received_data == 8'hF0) ||
                     (received_data == 8'hE1);
  // Controller acknowledge / BAT / echo / resend / error bytes carry no key meaning
  assign is_house  = (received_data == 8'hFA) || (received_data == 8'hAA) ||
                     (received_data == 8'hEE) || (received_data == 8'hFE) ||
                     (received_data == 8'hFF) || (received_data == 8'h00);

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    tmo_d   = tmo_q;
    err_d   = 1'b0;
    is_make = 1'b0;
    is_brk  = 1'b0;
    is_ext  = 1'b0;
    if (received_data_en) begin
      tmo_d = '0;
      case (state_q)
        StIdle: begin
          if (received_data == 8'hE0) begin
            state_d = StExt;
          end else if (received_data == 8'hF0) begin
            state_d = StBrk;
          end else if (received_data == 8'hE1) begin
            state_d = StSkip;
            skip_d  = 3'd7;
          end else if (!is_house) begin
            is_make = 1'b1;
          end
        end
        StExt: begin
          state_d = StIdle;
          if (received_data == 8'hF0) begin
            state_d = StExtBrk;
          end else if (is_prefix) begin
            err_d = 1'b1;
          end else begin
            is_make = 1'b1;
            is_ext  = 1'b1;
          end
        end
        StBrk, StExtBrk: begin
          state_d = StIdle;
          if (is_prefix) begin
            err_d = 1'b1;
          end else begin
            is_brk = 1'b1;
            is_ext = (state_q == StExtBrk);
          end
        end
        StSkip: begin
          skip_d = skip_q - 3'd1;
          if (skip_q <= 3'd1) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle) begin
      if (tmo_q == TmoLast) begin
        state_d = StIdle;
        err_d   = 1'b1;
        tmo_d   = '0;
      end else if (tmo_q != '1) begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_comb begin
    held_d  = held_q;
    press_d = '0;
    rel_d   = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if ((KEY_CODES[8*i +: 8] == received_data) && (KEY_EXT[i] == is_ext)) begin
        if (is_make) begin
          held_d[i] = 1'b1;
`ifdef KEY_TYPEMATIC_EN
          press_d[i] = 1'b1;
`else
          press_d[i] = ~held_q[i];
`endif
        end else if (is_brk) begin
          held_d[i] = 1'b0;
          rel_d[i]  = held_q[i];
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= StIdle;
      skip_q  <= '0;
      tmo_q   <= '0;
      held_q  <= '0;
      press_q <= '0;
      rel_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      tmo_q   <= tmo_d;
      held_q  <= held_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      err_q   <= err_d;
    end
  end

  assign key_held     = held_q;
  assign key_press    = press_q;
  assign key_release  = rel_q;
  assign any_held     = |held_q;
  assign decode_error = err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker with a short prefix timeout.
module tb_ps2_key_tracker;

  localparam int unsigned Tmo = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data = 8'h00;
  logic       en = 1'b0;
  logic [2:0] held, press, rel;
  logic       any_held, err;

  int n_tests = 0;
  int n_fail  = 0;
  int presses;
  int cyc;

  logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

  ps2_key_tracker #(
    .NUM_KEYS      (3),
    .KEY_CODES     (24'h74_6B_5A),
    .KEY_EXT       (3'b110),
    .PREFIX_TIMEOUT(Tmo)
  ) dut (
    .CLOCK_50        (clk),
    .reset           (reset),
    .received_data   (data),
    .received_data_en(en),
    .key_held        (held),
    .key_press       (press),
    .key_release     (rel),
    .any_held        (any_held),
    .decode_error    (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Strobe one byte; returns on the negedge after the strobe edge, outputs then valid.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    data = b;
    en   = 1'b1;
    @(negedge clk);
    en   = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    check_eq("rst_held", held, 3'b000);
    check_eq("rst_press", press, 3'b000);
    check_eq("rst_rel", rel, 3'b000);
    check_eq("rst_any", any_held, 1'b0);
    check_eq("rst_err", err, 1'b0);

    // Enter make / break
    send(8'h5A);
    check_eq("enter_held", held, 3'b001);
    check_eq("enter_press", press, 3'b001);
    check_eq("enter_any", any_held, 1'b1);
    tick();
    check_eq("enter_press_1cyc", press, 3'b000);
    send(8'hF0);
    check_eq("f0_no_change", {held, rel}, {3'b001, 3'b000});
    send(8'h5A);
    check_eq("enter_brk_held", held, 3'b000);
    check_eq("enter_rel", rel, 3'b001);
    tick();
    check_eq("enter_rel_1cyc", rel, 3'b000);

    // Extended Left / Right
    send(8'hE0); send(8'h6B);
    check_eq("left_held", held, 3'b010);
    check_eq("left_press", press, 3'b010);
    send(8'hE0); send(8'h74);
    check_eq("right_held", held, 3'b110);
    check_eq("right_press", press, 3'b100);
    send(8'hE0); send(8'hF0); send(8'h6B);
    check_eq("left_brk_held", held, 3'b100);
    check_eq("left_rel", rel, 3'b010);
    send(8'hE0); send(8'hF0); send(8'h74);
    check_eq("right_brk_held", held, 3'b000);
    // Non-extended 6B is not Left
    send(8'h6B);
    check_eq("plain_6b", {held, press}, 6'b0);

    // Typematic repeats
    presses = 0;
    for (int i = 0; i < 3; i++) begin
      send(8'h5A);
      presses += int'(press[0]);
    end
`ifdef KEY_TYPEMATIC_EN
    check_eq("repeat_press", presses, 3);
`else
    check_eq("repeat_press", presses, 1);
`endif
    check_eq("repeat_held", held, 3'b001);
    send(8'hF0); send(8'h5A);
    check_eq("repeat_brk", held, 3'b000);

    // Prefix timeout
    send(8'hE0);
    cyc = 0;
    while (!err && cyc < 3 * Tmo) begin
      tick();
      cyc++;
    end
    check_eq("tmo_cycles", cyc, Tmo);
    tick();
    check_eq("tmo_err_1cyc", err, 1'b0);
    send(8'h6B);
    check_eq("tmo_then_6b", {held, press}, 6'b0);

    // Pause sequence is swallowed
    for (int i = 0; i < 8; i++) begin
      send(pause_seq[i]);
      check_eq("pause_quiet", {held, press, rel, err}, 10'b0);
    end
    send(8'h5A);
    check_eq("after_pause", held, 3'b001);
    send(8'hF0); send(8'h5A);

    // Reset mid-sequence
    send(8'hE0); send(8'h6B);
    check_eq("hold_left", held, 3'b010);
    send(8'hE0); send(8'hF0);
    do_reset();
    check_eq("midrst_out", {held, press, rel, any_held, err}, 11'b0);
    send(8'hE0);
    do_reset();
    send(8'h6B);
    check_eq("midrst_discard", {held, press}, 6'b0);
    send(8'hFA); send(8'hAA);
    check_eq("house_ignored", {held, press, err}, 7'b0);
    send(8'hF0); send(8'hF0);
    check_eq("f0f0_err", err, 1'b1);
    tick();
    check_eq("f0f0_err_1cyc", err, 1'b0);
    send(8'hE0); send(8'hE0);
    check_eq("e0e0_err", err, 1'b1);
    send(8'h74);
    check_eq("after_err_idle", held, 3'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
